sar_search: RTL
===============

Name: sar_search

Overview:
- Successive-approximation search engine that drives an external magnitude comparator.
- Issues trial values (probes) and consumes the comparator's 2-bit relation code.
- Narrows onto a hidden target value one bit per accepted response, MSB first.
- Sits on the initiator side of the team's magnitude-comparator interface; the comparator is the responder.

Parameters:
- WIDTH, 4, width of probe, target and result in bits (must be >= 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- probe_valid  output  1  probe_data is a live trial value awaiting a response.
- probe_data  output  WIDTH  current trial value (the comparator's "a" operand).
- cmp_valid  input  1  cmp_code is a response to the current probe.
- cmp_code  input  2  relation of probe to target: 2'b10 probe>target, 2'b01 probe<target, 2'b00 equal, 2'b11 illegal.
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse at end of a search.
- result  output  WIDTH  found value; held from done until the next start is accepted.
- err  output  1  last search ended on an illegal code; held until the next start is accepted.

Behaviour:
- Reset values: state IDLE; probe_valid=0, probe_data=0, busy=0, done=0, result=0, err=0; internal bit index = WIDTH-1.
- States: IDLE, PROBE, DONE.
- IDLE:
  - On start=1: go to PROBE next cycle.
  - Load probe_data = 1 << (WIDTH-1); set bit index = WIDTH-1; clear err.
  - In PROBE: busy=1, probe_valid=1.
- PROBE:
  - probe_valid stays 1 every cycle.
  - A transaction completes on each edge with probe_valid && cmp_valid. cmp_valid may already be high in the first PROBE cycle.
  - With cmp_valid=0: probe_data holds.
- Response 2'b00 (equal): result <= probe_data; go to DONE. Early termination is allowed.
- Response 2'b10: clear bit[idx] of the probe.
- Response 2'b01: keep bit[idx] of the probe.
- After a 2'b10 or 2'b01 response:
  - If idx > 0: set bit[idx-1], decrement idx, stay in PROBE. The new probe is visible in the next cycle.
  - If idx == 0: result <= updated probe; go to DONE.
- Response 2'b11: err <= 1; result <= 0; go to DONE.
- DONE:
  - done=1, busy=0, probe_valid=0 for exactly one cycle; then IDLE.
- Latency:
  - At most WIDTH accepted responses.
  - With zero-wait responses, done is asserted WIDTH+1 cycles after the start edge.
- start while busy or in DONE: ignored; no queueing.
- Reset asserted mid-search: all outputs return to reset values immediately and asynchronously. No done pulse is issued.

Optional Feature:
- Macro: SAR_PROBE_CNT_EN.
- With the macro defined:
  - Adds output probe_cnt, width $clog2(WIDTH+1).
  - probe_cnt clears on an accepted start and increments on each accepted response.
  - Its value is held from done until the next start; reset value 0.
- Without the macro: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package cmp_pkg holds:
  - The code constants CMP_GT=2'b10, CMP_LT=2'b01, CMP_EQ=2'b00, CMP_BAD=2'b11.
  - The state enum {IDLE, PROBE, DONE}.
- The comparator responder and the testbench import the same constants.
- No sub-module: the bit-update logic is a few lines and stays inline.

Test Plan:
- WIDTH=4, target 7, zero-wait responder:
  - Probes are 8(10), 4(01), 6(01), 7(00).
  - Required: done with result=7, err=0; probe_cnt=4 if the feature is enabled.
- Target 0:
  - Probes are 8, 4, 2, 1, each answered 10.
  - Required: result=0 after 4 responses; done exactly 5 cycles after start.
- Target 15:
  - Probes are 8, 12, 14 (each 01) then 15 (00).
  - Required: result=15.
- Responder inserts 3 idle cycles before each response:
  - Required: probe_data stable while cmp_valid=0; result is still correct.
- cmp_code=11 on the second probe:
  - Required: err=1, result=0, one done pulse.
  - A new start then clears err.
- Two scenarios on control timing:
  - start pulsed during PROBE: no effect on the search in progress.
  - rst_n low mid-search: busy=0, probe_valid=0 immediately, no done pulse.

Source files
------------

// File: rtl/cmp_pkg.sv
// ============================================================================
// Module : cmp_pkg
// Brief  : Relation codes and search-state encoding shared by the
//          magnitude-comparator initiator, responder and benches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_LT  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
// Module : sar_search
// Brief  : Successive-approximation search engine; issues MSB-first probes to
//          an external comparator and narrows onto the hidden target.
//          Optional probe counter output enabled by SAR_PROBE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sar_search
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             probe_valid,
    output logic [WIDTH-1:0] probe_data,
    input  logic             cmp_valid,
    input  logic [1:0]       cmp_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
`ifdef SAR_PROBE_CNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] probe_cnt
`endif
);

    localparam int c_idx_w = $clog2(WIDTH);

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_probe = PROBE;
    localparam logic [1:0] c_st_done  = DONE;

    localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_zero = '0;
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [WIDTH-1:0]   c_probe_init = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_probe;
    logic [WIDTH-1:0]   r_result;
    logic               r_err;
    logic [WIDTH-1:0]   w_upd;
    logic [WIDTH-1:0]   w_next;

    // w_upd resolves the current bit; w_next also arms the next lower trial bit.
    always_comb begin
        w_upd = r_probe;
        if (cmp_code == CMP_GT) begin
            w_upd[r_idx] = 1'b0;
        end
        w_next = w_upd;
        if (r_idx != c_idx_zero) begin
            w_next[r_idx - c_idx_one] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_idx    <= c_idx_top;
            r_probe  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_probe;
                        r_probe <= c_probe_init;
                        r_idx   <= c_idx_top;
                        r_err   <= 1'b0;
                    end
                end
                c_st_probe: begin
                    if (cmp_valid) begin
                        case (cmp_code)
                            CMP_EQ: begin
                                r_result <= r_probe;
                                r_state  <= c_st_done;
                            end
                            CMP_BAD: begin
                                r_err    <= 1'b1;
                                r_result <= '0;
                                r_state  <= c_st_done;
                            end
                            CMP_GT, CMP_LT: begin
                                if (r_idx == c_idx_zero) begin
                                    r_result <= w_upd;
                                    r_state  <= c_st_done;
                                end else begin
                                    r_probe <= w_next;
                                    r_idx   <= r_idx - c_idx_one;
                                end
                            end
                            default: r_state <= c_st_done;
                        endcase
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

`ifdef SAR_PROBE_CNT_EN
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == c_st_idle && start) begin
            r_cnt <= '0;
        end else if (r_state == c_st_probe && cmp_valid) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign probe_cnt = r_cnt;
`endif

    assign busy        = (r_state == c_st_probe);
    assign probe_valid = (r_state == c_st_probe);
    assign done        = (r_state == c_st_done);
    assign probe_data  = r_probe;
    assign result      = r_result;
    assign err         = r_err;

endmodule

`default_nettype wire
